// File: rtl/uart_matrix_loader.sv
// uart_matrix_loader
// Parses a UART byte stream of whitespace-separated ASCII decimal tokens into
// a row count, a column count and row-major matrix elements. Each accepted
// element produces a single write strobe to matrix storage.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse, arms a new load (honoured only in IDLE)
//   rx_data    received byte, valid while rx_done is high
//   rx_done    one-cycle received-byte strobe
//   busy       high while a load is in progress
//   rows/cols  last committed dimensions
//   wr_en      one-cycle storage write strobe, with wr_addr/wr_data
//   load_done  one-cycle pulse after the final element write
//   err        one-cycle pulse on abort; err_code holds the cause
//              (1 illegal char, 2 out of range, 3 timeout)
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for start, bytes dropped
// GET_M    | accumulating the row-count token
// GET_N    | accumulating the column-count token
// GET_ELEM | accumulating element tokens, one write per commit
// DONE     | final element written, load_done pulses next cycle
// ERROR    | err high for this cycle, then back to IDLE

module uart_matrix_loader #(
    parameter int MAX_DIM     = 5,
    parameter int MAX_VAL     = 9,
    parameter int ADDR_W      = 5,
    parameter int TIMEOUT_CYC = 20_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic              busy,
    output logic [2:0]        rows,
    output logic [2:0]        cols,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              load_done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam int CW = ((ADDR_W > 6) ? ADDR_W : 6) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_M,
        S_GET_N,
        S_GET_ELEM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state, state_next;

    logic [7:0]        acc;
    logic              pending;
    logic [ADDR_W-1:0] idx;
    logic [TW-1:0]     tmr;

    logic        is_digit, is_sep, commit, in_get, tmr_tc;
    logic [11:0] acc_mul;
    logic [7:0]  acc_sat;
    logic        dim_ok, val_ok, last_elem;
    logic [5:0]  total;
    logic [CW-1:0] idx_inc;

    logic       do_write, set_rows, set_cols, go_err;
    logic [1:0] code_next;

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_sep   = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign commit   = rx_done && is_sep && pending;
    assign in_get   = (state == S_GET_M) || (state == S_GET_N) || (state == S_GET_ELEM);

    // Worst case 255*10+9 = 2559 fits in 12 bits before saturation.
    assign acc_mul = ({4'b0, acc} * 12'd10) + {8'b0, rx_data[3:0]};
    assign acc_sat = (acc_mul > 12'd255) ? 8'hFF : acc_mul[7:0];

    assign dim_ok = (acc != 8'd0) && (acc <= 8'(MAX_DIM));
    assign val_ok = (acc <= 8'(MAX_VAL));

    // Element index is already the linear row*cols+col address in row-major order.
    assign total     = {3'b0, rows} * {3'b0, cols};
    assign idx_inc   = CW'(idx) + CW'(1);
    assign last_elem = (idx_inc == CW'(total));

    // Down-counter reloaded on every byte; the error lands exactly
    // TIMEOUT_CYC cycles after the last rx_done.
    assign tmr_tc = (tmr <= TW'(1));

    assign busy = in_get || (state == S_DONE);
    assign err  = (state == S_ERROR);

    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        set_rows   = 1'b0;
        set_cols   = 1'b0;
        go_err     = 1'b0;
        code_next  = 2'd0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_GET_M;
            end
            S_GET_M, S_GET_N, S_GET_ELEM: begin
                if (rx_done) begin
                    if (!is_digit && !is_sep) begin
                        go_err    = 1'b1;
                        code_next = 2'd1;
                    end else if (commit) begin
                        case (state)
                            S_GET_M: begin
                                if (dim_ok) begin
                                    set_rows   = 1'b1;
                                    state_next = S_GET_N;
                                end else begin
                                    go_err    = 1'b1;
                                    code_next = 2'd2;
                                end
                            end
                            S_GET_N: begin
                                if (dim_ok) begin
                                    set_cols   = 1'b1;
                                    state_next = S_GET_ELEM;
                                end else begin
                                    go_err    = 1'b1;
                                    code_next = 2'd2;
                                end
                            end
                            default: begin
                                if (val_ok) begin
                                    do_write = 1'b1;
                                    if (last_elem) state_next = S_DONE;
                                end else begin
                                    go_err    = 1'b1;
                                    code_next = 2'd2;
                                end
                            end
                        endcase
                    end
                end else if (tmr_tc) begin
                    go_err    = 1'b1;
                    code_next = 2'd3;
                end
                if (go_err) state_next = S_ERROR;
            end
            S_DONE:  state_next = S_IDLE;
            S_ERROR: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            pending   <= 1'b0;
            idx       <= '0;
            tmr       <= '0;
            rows      <= '0;
            cols      <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            load_done <= 1'b0;
            err_code  <= '0;
        end else begin
            wr_en     <= do_write;
            load_done <= (state == S_DONE);
            if (state == S_IDLE && start) begin
                acc     <= '0;
                pending <= 1'b0;
                idx     <= '0;
                tmr     <= TMR_LOAD;
            end else if (in_get) begin
                if (rx_done) begin
                    tmr <= TMR_LOAD;
                    if (is_digit) begin
                        acc     <= acc_sat;
                        pending <= 1'b1;
                    end else if (commit) begin
                        acc     <= '0;
                        pending <= 1'b0;
                    end
                end else if (tmr != '0) begin
                    tmr <= tmr - TW'(1);
                end
            end
            if (do_write) begin
                wr_addr <= idx;
                wr_data <= acc;
                idx     <= idx + ADDR_W'(1);
            end
            if (set_rows) rows <= acc[2:0];
            if (set_cols) cols <= acc[2:0];
            if (go_err)   err_code <= code_next;
        end
    end

endmodule

// File: tb/tb_uart_matrix_loader.sv
module tb_uart_matrix_loader;

    logic       clk = 1'b0;
    logic       rst_n, start, rx_done;
    logic [7:0] rx_data;
    logic       busy, wr_en, load_done, err;
    logic [2:0] rows, cols;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    uart_matrix_loader #(
        .MAX_DIM(5), .MAX_VAL(9), .ADDR_W(5), .TIMEOUT_CYC(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data),
        .rx_done(rx_done), .busy(busy), .rows(rows), .cols(cols),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .load_done(load_done), .err(err), .err_code(err_code)
    );

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int last_rx_cyc = 0;
    logic [1:0] err_code_seen = 2'd0;
    logic prev_wr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer plus event capture for load_done / err.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (wr_en) begin
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                end
            end
            if (load_done) begin
                done_cnt++;
                check("done_after_last_wr", 32'(prev_wr), 32'd1);
                check("busy_at_done", 32'(busy), 32'd0);
            end
            if (err) begin
                err_cnt++;
                err_code_seen = err_code;
                err_cyc = cyc;
                check("busy_at_err", 32'(busy), 32'd0);
            end
            prev_wr = wr_en;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        last_rx_cyc = cyc;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_wr(input int a, input int d);
        exp_q.push_back('{addr: 5'(a), data: 8'(d)});
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 100 && done_cnt < target; i++) @(negedge clk);
        check("load_done_count", 32'(done_cnt), 32'(target));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_err(input int target, input int code, input int bound);
        for (int i = 0; i < bound && err_cnt < target; i++) @(negedge clk);
        check("err_count", 32'(err_cnt), 32'(target));
        check("err_code", 32'(err_code_seen), 32'(code));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rst_n = 1'b0;
        start = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dims", 32'({rows, cols}), 32'd0);
        check("rst_wr", 32'({wr_en, wr_addr, wr_data}), 32'd0);
        check("rst_flags", 32'({load_done, err, err_code}), 32'd0);
        rst_n = 1'b1;

        // Basic 2x3 load
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) push_wr(i, i + 1);
        send_str("2 3\n1 2 3\n4 5 6\n");
        wait_done(1);
        check("rows_2x3", 32'(rows), 32'd2);
        check("cols_2x3", 32'(cols), 32'd3);
        check("busy_after_done", 32'(busy), 32'd0);

        // Separator runs
        pulse_start();
        push_wr(0, 7);
        send_str("  1\r\n\n1   7 ");
        wait_done(2);
        check("rows_1x1", 32'(rows), 32'd1);
        check("cols_1x1", 32'(cols), 32'd1);

        // Dimension out of range: too big, then zero
        pulse_start();
        send_str("6 ");
        wait_err(1, 2, 50);
        check("rows_held", 32'(rows), 32'd1);
        pulse_start();
        send_str("0 ");
        wait_err(2, 2, 50);

        // Illegal character after one write, then a clean reload
        pulse_start();
        push_wr(0, 1);
        send_str("2 2 1 x");
        wait_err(3, 1, 50);
        check("partial_write_seen", 32'(exp_q.size()), 32'd0);
        pulse_start();
        push_wr(0, 3);
        send_str("1 1 3 ");
        wait_done(3);
        check("err_code_holds", 32'(err_code), 32'd1);

        // Timeout
        pulse_start();
        send_str("2 ");
        wait_err(4, 3, 200);
        check("timeout_latency", 32'(err_cyc - last_rx_cyc), 32'd100);
        check("rows_before_timeout", 32'(rows), 32'd2);

        // Saturating value out of range
        pulse_start();
        send_str("1 1 300 ");
        wait_err(5, 2, 50);

        // start while busy has no effect
        pulse_start();
        send_str("1 2 ");
        pulse_start();
        push_wr(0, 4);
        push_wr(1, 5);
        send_str("4 5 ");
        wait_done(4);
        check("cols_1x2", 32'(cols), 32'd2);

        // start and rx_done together in IDLE: the byte is dropped
        @(negedge clk);
        start = 1'b1;
        rx_data = 8'h39;
        rx_done = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        push_wr(0, 8);
        send_str("1 1 8 ");
        wait_done(5);

        // Reset mid-load
        pulse_start();
        push_wr(0, 1);
        send_str("2 2 1 ");
        e0 = err_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_dims", 32'({rows, cols}), 32'd0);
        check("midrst_outs", 32'({wr_en, wr_addr, wr_data, load_done, err, err_code}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_err", 32'(err_cnt), 32'(e0));
        check("midrst_idle", 32'(busy), 32'd0);
        check("midrst_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_matrix_loader.md
# uart_matrix_loader

Command-level controller that sits between the byte-level UART receiver and matrix storage. It consumes the receiver's byte stream (`rx_data`/`rx_done`) and parses whitespace-separated ASCII decimal tokens as a row count, a column count, then the elements in row-major order. It sequences one storage write per element and reports completion or a coded error. The top-level FSM arms it with `start` whenever a matrix must be entered over serial.

## Interface
- `MAX_DIM`, default 5: largest legal row or column count.
- `MAX_VAL`, default 9: largest legal element value.
- `ADDR_W`, default 5: width of the linear write address; must satisfy `MAX_DIM*MAX_DIM <= 2**ADDR_W`.
- `TIMEOUT_CYC`, default 20_000_000: maximum number of idle cycles between bytes while busy (1 s at 20 MHz).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that arms a new load.
- rx_data  in  8  received byte; valid only while `rx_done` is high.
- rx_done  in  1  one-cycle strobe marking a received byte.
- busy  out  1  high from the accepted `start` until done or error.
- rows  out  3  committed row count.
- cols  out  3  committed column count.
- wr_en  out  1  one-cycle write strobe to matrix storage.
- wr_addr  out  ADDR_W  linear index, `row*cols+col`.
- wr_data  out  8  element value.
- load_done  out  1  one-cycle pulse after the last element is written.
- err  out  1  one-cycle pulse when a load aborts.
- err_code  out  2  error cause: 1 = illegal character, 2 = out of range, 3 = timeout. Holds until the next `err`.

## Operation
- States: IDLE, GET_M, GET_N, GET_ELEM, DONE, ERROR.
- IDLE: all bytes are dropped. `start` moves the FSM to GET_M and clears the accumulator, the element index and the timeout counter. `start` is ignored in every other state.
- Byte classes:
  - Digit, `0x30`–`0x39`: `acc <= acc*10 + digit`. `acc` is 8 bits and saturates at 255. A pending flag is set.
  - Separator, `0x20`, `0x0D` or `0x0A`: if the pending flag is set, the token commits and the flag clears. If it is clear, the byte is ignored, so runs of separators are legal.
  - Any other byte: go to ERROR with code 1.
- Token commit in GET_M or GET_N:
  - Value 0 or value > `MAX_DIM`: go to ERROR with code 2.
  - Otherwise latch the value into `rows` (in GET_M) or `cols` (in GET_N) and advance to the next state.
- Token commit in GET_ELEM:
  - Value > `MAX_VAL`: go to ERROR with code 2.
  - Otherwise issue a write with `wr_data` = value and `wr_addr` = element index (0-based), then increment the index.
  - When the index reaches `rows*cols`, go to DONE.
- The last element needs a trailing separator to commit.
- DONE: assert `load_done` for one cycle, then return to IDLE.
- ERROR: assert `err` for one cycle and latch `err_code`, then return to IDLE. Elements already written are not retracted.
- Timeout: a counter runs while busy and resets on every `rx_done`. When it reaches `TIMEOUT_CYC`, go to ERROR with code 3.
- `rows` and `cols` hold their last committed values across loads and change only when a new dimension token commits.

## Timing
- Reset value of every output is 0.
- A byte is sampled on the edge where `rx_done` is high.
- Results appear one cycle after the committing separator's `rx_done`:
  - `wr_en`, `wr_addr` and `wr_data` are valid together in that cycle.
  - `rows` and `cols` update in that cycle.
- `load_done` is high in the cycle after the final `wr_en`.
- `busy` falls in the same cycle as `load_done` or `err`.
- `err` is high one cycle after the offending byte, or one cycle after the timeout count is reached.
- `start` and `rx_done` in the same IDLE cycle: `start` wins and that byte is dropped.
- `rx_done` and timeout expiry in the same cycle: the byte wins and the counter resets.
- Reset asserted mid-load: immediate return to IDLE with all outputs 0, and no `err` pulse.
- No backpressure: storage must accept a write on every cycle in which `wr_en` is high.

## Test plan
- Send `start`, then "2 3\n1 2 3\n4 5 6\n": 6 writes with addresses 0–5 and data 1–6, `rows`=2, `cols`=3, one `load_done` pulse, `busy` low afterwards.
- Send "  1\r\n\n1   7 ": separator runs are ignored, a single write with address 0 and data 7, then `load_done`.
- Send "6 " as the row count: `err` pulse with `err_code`=2, no writes, FSM back in IDLE. Send "0 ": same result.
- Send "2 2 1 x": one write with address 0 and data 1, then `err` with `err_code`=1. A following `start` followed by "1 1 3 " loads correctly.
- With `TIMEOUT_CYC`=100, send "2 " and then nothing: `err` with `err_code`=3 exactly 100 cycles after the last `rx_done`.
- Send "1 1 300 ": saturated value 255 gives `err_code`=2. Separately, pulse `start` while busy (no effect) and assert reset mid-stream (all outputs 0, no `err`).
